// File: rtl/axis_unpack.sv
// axis_unpack: splits each wide upstream word into DATA_UP_WIDTH/DATA_DN_WIDTH
// narrow subwords, lowest subword first, with one subword per cycle sustained.
// Optional feature macro: AXIS_UNPACK_CNT_EN. When defined, up_cnt selects how
// many subwords of a word are emitted (0 or out-of-range means all of them).
// When undefined, up_cnt is ignored and every word emits all subwords.
//
// Handshake (both ports): a transfer happens in a cycle exactly when val and
// rdy are both high at the rising edge. A producer holds val and its payload
// stable until the transfer; rdy may depend on the partner's rdy but never on
// the partner's val.
module axis_unpack #(
  parameter int DATA_UP_WIDTH = 32,
  parameter int DATA_DN_WIDTH = 8,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_UP_WIDTH-1:0] up_data,
  input  logic [CNT_WIDTH-1:0]     up_cnt,
  input  logic                     up_last,
  input  logic                     up_val,
  output logic                     up_rdy,
  output logic [DATA_DN_WIDTH-1:0] dn_data,
  output logic                     dn_last,
  output logic                     dn_val,
  input  logic                     dn_rdy
);

  localparam int DATA_NB = DATA_UP_WIDTH / DATA_DN_WIDTH;
  localparam int REM_W   = $clog2(DATA_NB + 1);
  localparam logic [REM_W-1:0] REM_NB  = REM_W'(DATA_NB);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  // Illegal width combinations are rejected at elaboration.
  if ((DATA_UP_WIDTH % DATA_DN_WIDTH) != 0 || DATA_UP_WIDTH <= DATA_DN_WIDTH) begin : g_bad_width
    $error("axis_unpack: DATA_UP_WIDTH must be a multiple of and larger than DATA_DN_WIDTH");
  end
  if ((2 ** CNT_WIDTH) <= DATA_NB) begin : g_bad_cnt
    $error("axis_unpack: CNT_WIDTH too small to hold DATA_NB");
  end

  // EMPTY <=> rem == 0, BUSY <=> rem > 0. The state is kept as its own
  // register so checkers can observe it directly.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [REM_W-1:0]         eff_cnt;
  logic [DATA_UP_WIDTH-1:0] word_q, word_d;
  logic                     last_q, last_d;
  logic                     up_xfer;
  logic                     dn_xfer;

`ifdef AXIS_UNPACK_CNT_EN
  // Effective subword count of the incoming word; 0 or above DATA_NB means full.
  always_comb begin
    eff_cnt = REM_NB;
    if (up_cnt != '0 && int'(up_cnt) <= DATA_NB) begin
      eff_cnt = REM_W'(up_cnt);
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^up_cnt;
  assign eff_cnt    = REM_NB;
`endif

  // Outputs and next-state: load on upstream transfer, shift on downstream.
  always_comb begin
    up_rdy  = (state_q == ST_EMPTY) || (rem_q == REM_ONE && dn_rdy);
    dn_val  = (state_q == ST_BUSY);
    dn_data = word_q[DATA_DN_WIDTH-1:0];
    dn_last = (rem_q == REM_ONE) && last_q;
    up_xfer = up_val && up_rdy;
    dn_xfer = dn_val && dn_rdy;
    rem_d   = rem_q;
    word_d  = word_q;
    last_d  = last_q;
    if (up_xfer) begin
      // Covers the back-to-back case too: the final subword of the old word
      // leaves this same edge, so the new word replaces it with no bubble.
      rem_d  = eff_cnt;
      word_d = up_data;
      last_d = up_last;
    end else if (dn_xfer) begin
      rem_d  = rem_q - REM_ONE;
      word_d = word_q >> DATA_DN_WIDTH;
    end
    state_d = (rem_d != '0) ? ST_BUSY : ST_EMPTY;
  end

  // Control state; reset drops any partially emitted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  // Data holding register; its contents are irrelevant while EMPTY.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_axis_unpack.sv
// Directed/random bench for axis_unpack: upstream driver task, downstream
// monitor with expected-subword queue, stall stability checks, final report.
module tb_axis_unpack;

  localparam int UPW = 32;
  localparam int DNW = 8;
  localparam int CW  = 3;
  localparam int NB  = UPW / DNW;

  logic           clk = 1'b0;
  logic           rst;
  logic [UPW-1:0] up_data;
  logic [CW-1:0]  up_cnt;
  logic           up_last;
  logic           up_val;
  logic           up_rdy;
  logic [DNW-1:0] dn_data;
  logic           dn_last;
  logic           dn_val;
  logic           dn_rdy;

  int n_cmp = 0;
  int n_err = 0;
  int dn_cnt = 0;
  int rdy_mode = 0;
  logic [DNW:0] exp_q[$];

  axis_unpack #(.DATA_UP_WIDTH(UPW), .DATA_DN_WIDTH(DNW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_cnt(up_cnt), .up_last(up_last),
    .up_val(up_val), .up_rdy(up_rdy),
    .dn_data(dn_data), .dn_last(dn_last), .dn_val(dn_val), .dn_rdy(dn_rdy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed none expected event", tag);
  endtask

  // Reference model of how many subwords a word yields.
  function automatic int model_cnt(input logic [CW-1:0] cnt);
`ifdef AXIS_UNPACK_CNT_EN
    if (cnt == 0 || int'(cnt) > NB) return NB;
    return int'(cnt);
`else
    return NB;
`endif
  endfunction

  task automatic push_exp(input logic [UPW-1:0] data, input logic [CW-1:0] cnt, input logic last);
    int n;
    n = model_cnt(cnt);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(last && i == n - 1), data[i*DNW +: DNW]});
    end
  endtask

  // Drives one upstream word; returns the number of cycles it waited for up_rdy.
  task automatic send(input logic [UPW-1:0] data, input logic [CW-1:0] cnt,
                      input logic last, output int waits);
    bit done;
    waits   = 0;
    done    = 0;
    up_data = data;
    up_cnt  = cnt;
    up_last = last;
    up_val  = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (up_rdy === 1'b1) begin
        push_exp(data, cnt, last);
        done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) fail_now("up_accept_timeout");
    @(posedge clk);
    #1;
    up_val  = 1'b0;
    up_data = $urandom;
    up_cnt  = CW'($urandom_range(0, 7));
    up_last = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // dn_rdy generator: always-ready, or the 1,0,0 repeating pattern.
  initial begin
    int ph;
    ph = 0;
    dn_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      dn_rdy = (rdy_mode == 0) ? 1'b1 : (ph == 0);
    end
  end

  // Downstream monitor: scoreboard compare and stall-stability checks.
  always @(negedge clk) begin : monitor
    logic [DNW:0] held;
    logic [DNW:0] e;
    bit stalled;
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_val", {31'd0, dn_val}, 32'd1);
        chk("stall_hold", {23'd0, dn_last, dn_data}, {23'd0, held});
      end
      if (dn_val === 1'b1 && dn_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_subword");
        end else begin
          e = exp_q.pop_front();
          chk("dn_out", {23'd0, dn_last, dn_data}, {23'd0, e});
          dn_cnt++;
        end
      end
      stalled = (dn_val === 1'b1 && dn_rdy === 1'b0);
      held = {dn_last, dn_data};
    end
  end

  initial begin
    int w;
    int n0;
    rst = 1'b1;
    up_val = 1'b0;
    up_data = '0;
    up_cnt = '0;
    up_last = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dn_val", {31'd0, dn_val}, 0);
    chk("rst_dn_last", {31'd0, dn_last}, 0);
    chk("rst_up_rdy", {31'd0, up_rdy}, 1);

    // full word, latency 1
    send(32'h44332211, 3'd4, 1'b1, w);
    chk("lat1_val", {31'd0, dn_val}, 1);
    chk("lat1_data", {24'd0, dn_data}, 32'h11);
    drain();

    // back-to-back reload: 8 subwords, no gaps
    n0 = dn_cnt;
    send(32'hDDCCBBAA, 3'd0, 1'b0, w);
    chk("b2b_first_wait", w, 0);
    send(32'h00FFEEDD, 3'd0, 1'b1, w);
    chk("b2b_reload_wait", w, NB - 1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", dn_cnt - n0, 8);
    drain();

    // partial word
    send(32'h00003322, 3'd2, 1'b1, w);
    drain();
    chk("part_dn_val", {31'd0, dn_val}, 0);
    chk("part_up_rdy", {31'd0, up_rdy}, 1);

    // count of 1 (partial when enabled, full otherwise) and out-of-range count
    send(32'h44332211, 3'd1, 1'b1, w);
    drain();
    send(32'hA5B6C7D8, 3'd7, 1'b0, w);
    drain();

    // stalled downstream with random upstream gaps
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      send($urandom, CW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset mid-word
    send(32'h44332211, 3'd4, 1'b1, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_remaining", exp_q.size(), 2);
    exp_q.delete();
    chk("midrst_dn_val", {31'd0, dn_val}, 0);
    chk("midrst_dn_last", {31'd0, dn_last}, 0);
    chk("midrst_up_rdy", {31'd0, up_rdy}, 1);
    send(32'h88776655, 3'd4, 1'b1, w);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_dn_val", {31'd0, dn_val}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_unpack.md
AXIS_UNPACK -- requirements
Module: axis_unpack

Interface
REQ-001 SHALL have parameter DATA_UP_WIDTH, default 32, width of wide upstream word.
REQ-002 SHALL have parameter DATA_DN_WIDTH, default 8, width of narrow downstream word.
REQ-003 SHALL have parameter CNT_WIDTH, default 3, width of up_cnt; must hold DATA_NB = DATA_UP_WIDTH/DATA_DN_WIDTH.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 up_data  input  DATA_UP_WIDTH  wide word; subword 0 in bits [DATA_DN_WIDTH-1:0].
REQ-007 up_cnt  input  CNT_WIDTH  number of valid subwords in up_data, counted from subword 0; 0 means DATA_NB.
REQ-008 up_last  input  1  final wide word of a packet.
REQ-009 up_val  input  1  upstream word valid.
REQ-010 up_rdy  output  1  block can accept upstream word.
REQ-011 dn_data  output  DATA_DN_WIDTH  narrow subword.
REQ-012 dn_last  output  1  final subword of a packet.
REQ-013 dn_val  output  1  downstream subword valid.
REQ-014 dn_rdy  input  1  downstream accepts subword.

Function
REQ-015 Transfer SHALL occur on either port only in a cycle where val and rdy are both high; no other combination is a transfer.
REQ-016 DATA_UP_WIDTH SHALL be an integer multiple of DATA_DN_WIDTH and greater than it; other values are illegal and SHALL NOT be supported.
REQ-017 Block SHALL hold one wide word and a remaining-subword counter rem (0..DATA_NB); states: EMPTY (rem==0) and BUSY (rem>0).
REQ-018 On upstream transfer, word SHALL be registered and rem loaded with effective count (up_cnt, or DATA_NB if up_cnt is 0 or above DATA_NB); dn_val SHALL rise the following cycle (latency 1).
REQ-019 Subwords SHALL be emitted lowest index first; each downstream transfer SHALL shift the held word right by DATA_DN_WIDTH and decrement rem.
REQ-020 dn_val SHALL equal (rem != 0); dn_data SHALL be held subword 0; outputs SHALL remain stable while dn_val high and dn_rdy low.
REQ-021 dn_last SHALL be high only while rem==1 and the held word arrived with up_last; non-last words with partial count SHALL emit no dn_last.
REQ-022 up_rdy SHALL be high when rem==0, or when rem==1 and dn_rdy high (back-to-back reload), giving one subword per cycle sustained throughput.
REQ-023 Simultaneous final downstream transfer and upstream transfer SHALL load the new word with no bubble and no lost or duplicated subword.
REQ-024 up_rdy SHALL NOT depend combinationally on up_val.

Reset
REQ-025 Reset SHALL set rem to 0: dn_val=0, dn_last=0, up_rdy=1 in the cycle after rst is sampled high.
REQ-026 Reset mid-word SHALL discard remaining subwords; no subword of that word SHALL appear after reset.
REQ-027 dn_data SHALL be don't-care after reset until first load; no reset of the data register is required.

Configuration
REQ-028 Macro AXIS_UNPACK_CNT_EN SHALL control partial-word support.
REQ-029 With AXIS_UNPACK_CNT_EN defined: up_cnt honoured per REQ-018.
REQ-030 Without AXIS_UNPACK_CNT_EN: up_cnt port present but ignored; every word emits DATA_NB subwords; count logic not synthesised.

Verification (defaults, AXIS_UNPACK_CNT_EN defined unless stated)
REQ-031 up_data=0x44332211, up_cnt=4, up_last=1, dn_rdy=1 -> dn_data 0x11,0x22,0x33,0x44 on consecutive cycles starting 1 cycle after accept, dn_last only with 0x44.
REQ-032 Words 0xDDCCBBAA(cnt=0) then 0x00FFEEDD... sent back-to-back, dn_rdy=1 -> 8 subwords on 8 consecutive cycles, up_rdy high on each 4th subword, no gaps.
REQ-033 up_data=0x00003322, up_cnt=2, up_last=1 -> dn_data 0x22 then 0x33 with dn_last, then dn_val=0, up_rdy=1.
REQ-034 dn_rdy toggling 1,0,0,1,... with random up_val -> output sequence identical to dn_rdy=1 run; dn_data/dn_last stable while stalled.
REQ-035 rst asserted after 2 of 4 subwords of 0x44332211 -> dn_val=0 next cycle; 0x33,0x44 never emitted; next word 0x88776655 emitted intact.
REQ-036 Macro undefined, up_cnt=1, up_data=0x44332211, up_last=1 -> all four subwords emitted, dn_last with 0x44.
